rx_packet_assembler: RTL and testbench

RX_PACKET_ASSEMBLER -- requirements
Module: rx_packet_assembler

---
 rtl/rx_packet_assembler_if.sv | 31 +++
 rtl/rx_packet_assembler.sv | 78 +++++++
 tb/tb_rx_packet_assembler.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/rx_packet_assembler_if.sv
// rx_packet_assembler_if: bus between a UART receiver/controller and the
// two-byte packet assembler.
//   rx_valid      : one-cycle pulse, rx_byte is valid
//   rx_byte[7:0]  : received byte
//   clear         : synchronous flush request (controller's rest_uart_rx)
//   new_data      : one-cycle pulse, a complete packet has been published
//   next_command  : command byte of the last complete packet
//   next_address  : sensor address byte of the last complete packet
//   frame_error   : one-cycle pulse on an inter-byte timeout
//   busy          : high while a partial packet is held
// master = byte source / controller side, slave = assembler side.
interface rx_packet_assembler_if;
    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       clear;
    logic       new_data;
    logic [7:0] next_command;
    logic [7:0] next_address;
    logic       frame_error;
    logic       busy;

    modport master (
        output rx_valid, rx_byte, clear,
        input  new_data, next_command, next_address, frame_error, busy
    );

    modport slave (
        input  rx_valid, rx_byte, clear,
        output new_data, next_command, next_address, frame_error, busy
    );
endinterface

// File: rtl/rx_packet_assembler.sv
// rx_packet_assembler: collects a command byte followed by an address byte
// from a UART receiver and publishes them together as one packet.
//   clock : 50 MHz system clock, the only clock
//   reset : asynchronous, active-high
//   bus   : rx_packet_assembler_if.slave (see interface file for signals)
// TIMEOUT_CYCLES bounds the idle time allowed between byte 0 and byte 1;
// on expiry the held command is dropped and frame_error pulses.
module rx_packet_assembler #(
    parameter logic [27:0] TIMEOUT_CYCLES = 28'd5_000_000
) (
    input  logic                      clock,
    input  logic                      reset,
    rx_packet_assembler_if.slave      bus
);

    typedef enum logic {
        WAIT_CMD  = 1'b0,
        WAIT_ADDR = 1'b1
    } state_t;

    state_t      state;
    logic [27:0] idle_count;
    logic [7:0]  cmd_hold;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state            <= WAIT_CMD;
            idle_count       <= '0;
            cmd_hold         <= '0;
            bus.new_data     <= 1'b0;
            bus.frame_error  <= 1'b0;
            bus.next_command <= '0;
            bus.next_address <= '0;
        end else begin
            bus.new_data    <= 1'b0;
            bus.frame_error <= 1'b0;
            if (bus.clear) begin
                // clear outranks a coincident byte: the byte is dropped
                state            <= WAIT_CMD;
                idle_count       <= '0;
                cmd_hold         <= '0;
                bus.next_command <= '0;
                bus.next_address <= '0;
            end else begin
                case (state)
                    WAIT_CMD: begin
                        if (bus.rx_valid) begin
                            cmd_hold   <= bus.rx_byte;
                            idle_count <= '0;
                            state      <= WAIT_ADDR;
                        end
                    end
                    WAIT_ADDR: begin
                        // a byte arriving on the timeout cycle still completes the packet
                        if (bus.rx_valid) begin
                            bus.next_command <= cmd_hold;
                            bus.next_address <= bus.rx_byte;
                            bus.new_data     <= 1'b1;
                            idle_count       <= '0;
                            state            <= WAIT_CMD;
                        end else if (idle_count == TIMEOUT_CYCLES - 28'd1) begin
                            bus.frame_error <= 1'b1;
                            cmd_hold        <= '0;
                            idle_count      <= '0;
                            state           <= WAIT_CMD;
                        end else if (idle_count != '1) begin
                            idle_count <= idle_count + 28'd1;
                        end
                    end
                    default: state <= WAIT_CMD;
                endcase
            end
        end
    end

    assign bus.busy = (state == WAIT_ADDR);

endmodule

// File: tb/tb_rx_packet_assembler.sv
module tb_rx_packet_assembler;

    logic clock;
    logic reset;

    rx_packet_assembler_if bus ();

    rx_packet_assembler #(
        .TIMEOUT_CYCLES(28'd10)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #10 clock = ~clock;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned nd_count = 0;
    int unsigned fe_count = 0;
    logic [15:0] expq[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: every new_data sample pops one expected {cmd, addr}.
    always @(negedge clock) begin
        if (!reset) begin
            if (bus.frame_error) fe_count++;
            if (bus.new_data) begin
                logic [15:0] e;
                nd_count++;
                if (expq.size() == 0) begin
                    check("unexpected_new_data", 32'd1, 32'd0);
                end else begin
                    e = expq.pop_front();
                    check("pkt_command", {24'd0, bus.next_command}, {24'd0, e[15:8]});
                    check("pkt_address", {24'd0, bus.next_address}, {24'd0, e[7:0]});
                end
            end
        end
    end

    // Called at posedge+1; byte is sampled on the next edge, returns at that edge+1.
    task automatic send(input logic [7:0] b);
        bus.rx_byte  = b;
        bus.rx_valid = 1'b1;
        @(posedge clock);
        #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    int unsigned nd0;
    int unsigned fe0;

    initial begin
        reset        = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_byte  = '0;
        bus.clear    = 1'b0;
        idle(3);
        check("rst_new_data", {31'd0, bus.new_data}, 32'd0);
        check("rst_frame_error", {31'd0, bus.frame_error}, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_next_command", {24'd0, bus.next_command}, 32'd0);
        check("rst_next_address", {24'd0, bus.next_address}, 32'd0);
        reset = 1'b0;
        idle(2);

        // Basic packet, bytes three cycles apart
        nd0 = nd_count;
        send(8'h04);
        check("basic_busy_between", {31'd0, bus.busy}, 32'd1);
        idle(2);
        check("basic_no_pub_early", nd_count - nd0, 32'd0);
        expq.push_back(16'h0405);
        send(8'h05);
        check("basic_busy_after", {31'd0, bus.busy}, 32'd0);
        idle(3);
        check("basic_one_pulse", nd_count - nd0, 32'd1);
        check("basic_hold_cmd", {24'd0, bus.next_command}, 32'h04);
        check("basic_hold_addr", {24'd0, bus.next_address}, 32'h05);

        // Timeout: byte 0, then silence
        fe0 = fe_count;
        send(8'h01);
        check("to_busy", {31'd0, bus.busy}, 32'd1);
        idle(8);
        check("to_not_yet", fe_count - fe0, 32'd0);
        check("to_busy_still", {31'd0, bus.busy}, 32'd1);
        idle(4);
        check("to_fe_once", fe_count - fe0, 32'd1);
        check("to_busy_fell", {31'd0, bus.busy}, 32'd0);
        check("to_cmd_kept", {24'd0, bus.next_command}, 32'h04);
        check("to_addr_kept", {24'd0, bus.next_address}, 32'h05);
        send(8'h02);
        check("to_next_is_cmd", {31'd0, bus.busy}, 32'd1);
        expq.push_back(16'h0203);
        send(8'h03);
        idle(2);

        // Timeout tie: byte 1 on the exact timeout edge
        fe0 = fe_count;
        nd0 = nd_count;
        send(8'h11);
        repeat (9) @(posedge clock);
        #1;
        expq.push_back(16'h1122);
        send(8'h22);
        idle(3);
        check("tie_no_fe", fe_count - fe0, 32'd0);
        check("tie_published", nd_count - nd0, 32'd1);

        // Clear against a coincident byte
        expq.push_back(16'h0403);
        send(8'h04);
        send(8'h03);
        idle(1);
        nd0 = nd_count;
        send(8'h06);
        check("clr_partial_busy", {31'd0, bus.busy}, 32'd1);
        bus.clear = 1'b1;
        send(8'h03);
        bus.clear = 1'b0;
        idle(2);
        check("clr_cmd", {24'd0, bus.next_command}, 32'h00);
        check("clr_addr", {24'd0, bus.next_address}, 32'h00);
        check("clr_busy", {31'd0, bus.busy}, 32'd0);
        check("clr_no_new_data", nd_count - nd0, 32'd0);
        expq.push_back(16'h0708);
        send(8'h07);
        send(8'h08);
        idle(2);

        // Back-to-back packets
        nd0 = nd_count;
        expq.push_back(16'h0102);
        expq.push_back(16'h0304);
        for (int i = 1; i <= 4; i++) begin
            bus.rx_byte  = 8'(i);
            bus.rx_valid = 1'b1;
            @(posedge clock);
            #1;
        end
        bus.rx_valid = 1'b0;
        idle(3);
        check("b2b_two_pulses", nd_count - nd0, 32'd2);
        check("b2b_last_cmd", {24'd0, bus.next_command}, 32'h03);
        check("b2b_last_addr", {24'd0, bus.next_address}, 32'h04);

        // Asynchronous reset mid-packet, off the clock edge
        send(8'h09);
        #3;
        reset = 1'b1;
        #1;
        check("arst_busy", {31'd0, bus.busy}, 32'd0);
        check("arst_cmd", {24'd0, bus.next_command}, 32'h00);
        check("arst_addr", {24'd0, bus.next_address}, 32'h00);
        #12;
        reset = 1'b0;
        @(posedge clock);
        #1;
        nd0 = nd_count;
        send(8'h07);
        check("arst_held_cmd", {31'd0, bus.busy}, 32'd1);
        idle(2);
        check("arst_nothing_pub", nd_count - nd0, 32'd0);
        check("arst_cmd_zero", {24'd0, bus.next_command}, 32'h00);
        expq.push_back(16'h070A);
        send(8'h0A);

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 20 && expq.size() != 0; i++) @(posedge clock);
        idle(2);
        check("scoreboard_drained", expq.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
